// File: rtl/isolde_rf_wr_arbiter_pkg.sv
// Shared types and default widths for the ISOLDE register-file write-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package isolde_rf_wr_arbiter_pkg;

  localparam int ISOLDE_REG_COUNT  = 32;
  localparam int ISOLDE_REG_ADDR_W = $clog2(ISOLDE_REG_COUNT);
  localparam int ISOLDE_REG_DATA_W = 32;
  localparam int ISOLDE_REG_SIZE   = 4;
  localparam int ISOLDE_WR_NUM_REQ = 2;

  // Requester slot on the shared write port.
  typedef enum logic {
    ISOLDE_WR_DEC  = 1'b0,  // decoder load path (vle32_4)
    ISOLDE_WR_EXEC = 1'b1   // exec result path (gemm rd2)
  } isolde_wr_idx_e;

  // One quad-word write request.
  typedef struct packed {
    logic [ISOLDE_REG_ADDR_W-1:0]                 addr;
    logic [ISOLDE_REG_SIZE*ISOLDE_REG_DATA_W-1:0] data;
  } isolde_wr_req_t;

endpackage

// File: rtl/isolde_rr_arbiter.sv
// Round-robin grant over NumReq requesters with a rotating priority pointer.
// Latency: grant is combinational in the request cycle; pointer moves on the next edge.
// Backpressure: no grant while flush is high; ungranted requesters hold their request.
// Ports: clk/rst_n (async active-low), flush (sync clear of pointer, blocks grants),
//        req (valids), gnt (one-hot grant), gnt_idx (binary grant), gnt_vld (any grant).
module isolde_rr_arbiter #(
  parameter  int NumReq = 2,
  localparam int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [NumReq-1:0] req,
  output logic [NumReq-1:0] gnt,
  output logic [IdxW-1:0]   gnt_idx,
  output logic              gnt_vld
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] cand;
  logic            found;

  // Scan starting at the pointer and wrapping; first valid requester wins.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = IdxW'((int'(ptr_q) + k) % NumReq);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    gnt_vld = found & ~flush;
    gnt     = '0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  // Winner drops to lowest priority next cycle, bounding wait to NumReq cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (flush) begin
      ptr_q <= '0;
    end else if (gnt_vld) begin
      ptr_q <= (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);
    end
  end

endmodule

// File: rtl/isolde_rf_wr_arbiter.sv
// Shares the single RF write port between decoder and exec; tracks pending writes for hazards.
// Latency: 1 cycle from accepted request to rf_we_o; reservation visible in pend_o next cycle.
// Backpressure: req_ready_o one-hot per cycle, none during flush; rsv_ready_o low while target pending.
// Ports: req_* (valid/ready write requests), rsv_* (destination reservation at issue),
//        qry_* (two hazard queries), rf_* (to RF write port 0), pend_o (scoreboard).
module isolde_rf_wr_arbiter
  import isolde_rf_wr_arbiter_pkg::*;
#(
  parameter int NumReq   = ISOLDE_WR_NUM_REQ,
  parameter int RegCount = ISOLDE_REG_COUNT,
  parameter int RegAddrW = ISOLDE_REG_ADDR_W,
  parameter int RegDataW = ISOLDE_REG_DATA_W,
  parameter int RegSize  = ISOLDE_REG_SIZE
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq*RegAddrW-1:0]     req_addr_i,
  input  logic [NumReq*RegSize*RegDataW-1:0] req_data_i,
  input  logic                           rsv_valid_i,
  input  logic [RegAddrW-1:0]            rsv_addr_i,
  output logic                           rsv_ready_o,
  input  logic [2*RegAddrW-1:0]          qry_addr_i,
  output logic [1:0]                     qry_busy_o,
  output logic                           rf_we_o,
  output logic [RegAddrW-1:0]            rf_waddr_o,
  output logic [RegSize*RegDataW-1:0]    rf_wdata_o,
  output logic [RegCount-1:0]            pend_o
);

  localparam int IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int WordW = RegSize * RegDataW;

  logic [NumReq-1:0]   gnt;
  logic [IdxW-1:0]     gnt_idx;
  logic                gnt_vld;
  logic [RegAddrW-1:0] sel_addr;
  logic [WordW-1:0]    sel_data;
  logic [RegCount-1:0] pend_q;
  logic [RegCount-1:0] pend_d;

  isolde_rr_arbiter #(.NumReq(NumReq)) u_rr (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .flush   (flush_i),
    .req     (req_valid_i),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign req_ready_o = gnt;
  assign sel_addr    = req_addr_i[gnt_idx*RegAddrW +: RegAddrW];
  assign sel_data    = req_data_i[gnt_idx*WordW +: WordW];

  // Write stage: address/data hold when idle so the RF port sees no spurious toggles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      rf_we_o <= gnt_vld;
      if (gnt_vld) begin
        rf_waddr_o <= sel_addr;
        rf_wdata_o <= sel_data;
      end
    end
  end

  // A write landing this cycle resolves the pending bit, so it neither blocks a new
  // reservation nor reports busy.
  assign rsv_ready_o = ~pend_q[rsv_addr_i] | (rf_we_o & (rf_waddr_o == rsv_addr_i));

  always_comb begin
    qry_busy_o = '0;
    for (int k = 0; k < 2; k++) begin
      qry_busy_o[k] = pend_q[qry_addr_i[k*RegAddrW +: RegAddrW]] &
                      ~(rf_we_o & (rf_waddr_o == qry_addr_i[k*RegAddrW +: RegAddrW]));
    end
  end

  // Set is applied after clear so a same-cycle re-reservation keeps the bit.
  always_comb begin
    pend_d = pend_q;
    if (rf_we_o) pend_d[rf_waddr_o] = 1'b0;
    if (rsv_valid_i && rsv_ready_o) pend_d[rsv_addr_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else if (flush_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(req_ready_o));
  a_waddr_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rf_we_o |-> !$isunknown(rf_waddr_o));

  for (genvar g = 0; g < NumReq; g++) begin : g_hold_chk
    a_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[g] && !req_ready_o[g]) |=> (!req_valid_i[g] ||
        ($stable(req_addr_i[g*RegAddrW +: RegAddrW]) && $stable(req_data_i[g*WordW +: WordW]))));
  end

endmodule

// File: tb/tb_isolde_rf_wr_arbiter.sv
module tb_isolde_rf_wr_arbiter;
  import isolde_rf_wr_arbiter_pkg::*;

  localparam int N  = ISOLDE_WR_NUM_REQ;
  localparam int AW = ISOLDE_REG_ADDR_W;
  localparam int DW = ISOLDE_REG_SIZE * ISOLDE_REG_DATA_W;
  localparam int RC = ISOLDE_REG_COUNT;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            rsv_valid = 1'b0;
  logic [AW-1:0]   rsv_addr = '0;
  logic            rsv_ready;
  logic [2*AW-1:0] qry_addr = '0;
  logic [1:0]      qry_busy;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [RC-1:0]   pend;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  isolde_rf_wr_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .rsv_valid_i (rsv_valid),
    .rsv_addr_i  (rsv_addr),
    .rsv_ready_o (rsv_ready),
    .qry_addr_i  (qry_addr),
    .qry_busy_o  (qry_busy),
    .rf_we_o     (rf_we),
    .rf_waddr_o  (rf_waddr),
    .rf_wdata_o  (rf_wdata),
    .pend_o      (pend)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  bit [RC-1:0] m_pend     = '0;
  int          m_ptr      = 0;
  bit          m_we       = 1'b0;
  bit [AW-1:0] m_waddr    = '0;
  bit [DW-1:0] m_wdata    = '0;
  int          m_last_gnt = -1;

  // Winner is the valid requester closest after the pointer in circular distance.
  function automatic int model_grant(input logic [N-1:0] v, input int ptr, input logic fl);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    if (fl) return -1;
    for (int i = 0; i < N; i++) begin
      d = (i - ptr + N) % N;
      if (v[i] && d < bestd) begin
        bestd = d;
        best  = i;
      end
    end
    return best;
  endfunction

  function automatic bit writing(input logic [AW-1:0] a);
    return m_we && (m_waddr == a);
  endfunction

  task automatic m_reset();
    m_pend = '0; m_ptr = 0; m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_last_gnt = -1;
  endtask

  always @(negedge rst_n) m_reset();

  always @(posedge clk) begin
    int  g;
    bit  rr;
    if (!rst_n) begin
      m_reset();
    end else begin
      g  = model_grant(req_valid, m_ptr, flush);
      rr = !m_pend[rsv_addr] || writing(rsv_addr);
      if (m_we) m_pend[m_waddr] = 1'b0;
      if (rsv_valid && rr) m_pend[rsv_addr] = 1'b1;
      if (flush) begin
        m_pend = '0;
        m_ptr  = 0;
      end
      m_last_gnt = g;
      m_we       = (g >= 0);
      if (g >= 0) begin
        m_waddr = req_addr[g*AW +: AW];
        m_wdata = req_data[g*DW +: DW];
        m_ptr   = (g + 1) % N;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int          g;
    logic [N-1:0] eg;
    logic [1:0]  eb;
    logic [AW-1:0] q;
    g  = model_grant(req_valid, m_ptr, flush);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    eb = '0;
    for (int k = 0; k < 2; k++) begin
      q = qry_addr[k*AW +: AW];
      eb[k] = m_pend[q] && !writing(q);
    end
    chk("m_req_ready", DW'(req_ready), DW'(eg));
    chk("m_rsv_ready", DW'(rsv_ready), DW'(!m_pend[rsv_addr] || writing(rsv_addr)));
    chk("m_qry_busy", DW'(qry_busy), DW'(eb));
    chk("m_rf_we", DW'(rf_we), DW'(m_we));
    chk("m_rf_waddr", DW'(rf_waddr), DW'(m_waddr));
    chk("m_rf_wdata", rf_wdata, m_wdata);
    chk("m_pend", DW'(pend), DW'(m_pend));
  end

  // ---------------- stimulus ----------------
  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]        = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [DW-1:0] d0, d1, d2, d3, d4;

  initial begin
    d0 = rnd_data(); d1 = rnd_data(); d2 = rnd_data(); d3 = rnd_data(); d4 = rnd_data();
    smp();
    chk("rst_we", DW'(rf_we), DW'(1'b0));
    chk("rst_pend", DW'(pend), DW'(0));
    #7 rst_n = 1'b1;
    nxt();

    // 1: single decoder request
    set_req(0, 1'b1, AW'(3), d0);
    smp(); chk("t1_ready", DW'(req_ready), DW'(2'b01));
    nxt(); set_req(0, 1'b0, AW'(3), d0);
    smp();
    chk("t1_we", DW'(rf_we), DW'(1'b1));
    chk("t1_waddr", DW'(rf_waddr), DW'(3));
    chk("t1_wdata", rf_wdata, d0);
    nxt(); flush = 1'b1;
    nxt(); flush = 1'b0;

    // 2: contention, grants alternate starting at the decoder
    set_req(0, 1'b1, AW'(5), d1);
    set_req(1, 1'b1, AW'(9), d2);
    for (int c = 0; c < 4; c++) begin
      smp();
      chk("t2_ready", DW'(req_ready), (c % 2 == 0) ? DW'(2'b01) : DW'(2'b10));
      if (c > 0) begin
        chk("t2_we", DW'(rf_we), DW'(1'b1));
        chk("t2_waddr", DW'(rf_waddr), (c % 2 == 1) ? DW'(5) : DW'(9));
      end
      nxt();
    end
    set_req(0, 1'b0, AW'(5), d1);
    set_req(1, 1'b0, AW'(9), d2);
    smp(); chk("t2_we_last", DW'(rf_we), DW'(1'b1)); chk("t2_waddr_last", DW'(rf_waddr), DW'(9));
    nxt(); smp(); chk("t2_we_idle", DW'(rf_we), DW'(1'b0));

    // 3: reserve 7, query, then exec writes 7
    nxt(); rsv_valid = 1'b1; rsv_addr = AW'(7); qry_addr = {AW'(0), AW'(7)};
    smp(); chk("t3_rsv_ready", DW'(rsv_ready), DW'(1'b1));
    nxt(); rsv_valid = 1'b0; set_req(1, 1'b1, AW'(7), d3);
    smp();
    chk("t3_pend", DW'(pend), DW'(32'h80));
    chk("t3_busy", DW'(qry_busy), DW'(2'b01));
    chk("t3_ready", DW'(req_ready), DW'(2'b10));
    nxt(); set_req(1, 1'b0, AW'(7), d3);
    smp();
    chk("t3_we", DW'(rf_we), DW'(1'b1));
    chk("t3_busy_wr", DW'(qry_busy), DW'(2'b00));
    chk("t3_pend_wr", DW'(pend), DW'(32'h80));
    nxt(); smp(); chk("t3_pend_clr", DW'(pend), DW'(0));

    // 4: double reservation blocked; write+reserve same cycle keeps the bit
    nxt(); rsv_valid = 1'b1; rsv_addr = AW'(7);
    smp(); chk("t4_rsv1", DW'(rsv_ready), DW'(1'b1));
    nxt(); smp(); chk("t4_rsv2", DW'(rsv_ready), DW'(1'b0));
    nxt(); rsv_valid = 1'b0; set_req(0, 1'b1, AW'(7), d4);
    smp(); chk("t4_ready", DW'(req_ready), DW'(2'b01));
    nxt(); set_req(0, 1'b0, AW'(7), d4); rsv_valid = 1'b1; rsv_addr = AW'(7);
    smp(); chk("t4_rsv_wr", DW'(rsv_ready), DW'(1'b1)); chk("t4_busy_wr", DW'(qry_busy[0]), DW'(1'b0));
    nxt(); rsv_addr = AW'(4);
    smp(); chk("t4_pend_kept", DW'(pend), DW'(32'h80));
    nxt(); rsv_valid = 1'b0;

    // 5: flush with pend=0x90 and both requests valid
    flush = 1'b1;
    set_req(0, 1'b1, AW'(1), d0);
    set_req(1, 1'b1, AW'(2), d1);
    smp(); chk("t5_pend", DW'(pend), DW'(32'h90)); chk("t5_ready", DW'(req_ready), DW'(2'b00));
    nxt(); flush = 1'b0;
    smp();
    chk("t5_pend_clr", DW'(pend), DW'(0));
    chk("t5_we", DW'(rf_we), DW'(1'b0));
    chk("t5_ptr0", DW'(req_ready), DW'(2'b01));
    nxt(); set_req(0, 1'b0, AW'(1), d0);
    smp(); chk("t5_ready1", DW'(req_ready), DW'(2'b10)); chk("t5_waddr", DW'(rf_waddr), DW'(1));
    nxt(); set_req(1, 1'b0, AW'(2), d1);
    smp(); chk("t5_waddr2", DW'(rf_waddr), DW'(2));

    // 6: async reset while a write is in flight
    nxt(); rsv_valid = 1'b1; rsv_addr = AW'(3); set_req(0, 1'b1, AW'(11), d2);
    nxt(); rsv_valid = 1'b0; set_req(0, 1'b0, AW'(11), d2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_we", DW'(rf_we), DW'(1'b0));
    chk("t6_waddr", DW'(rf_waddr), DW'(0));
    chk("t6_wdata", rf_wdata, DW'(0));
    chk("t6_pend", DW'(pend), DW'(0));
    smp(); #2 rst_n = 1'b1;
    nxt(); smp(); chk("t6_we_after", DW'(rf_we), DW'(1'b0));
    nxt(); smp(); chk("t6_we_after2", DW'(rf_we), DW'(1'b0));

    // randomized traffic; pending requests are held until granted
    nxt();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && m_last_gnt != i))
          set_req(i, ($urandom_range(2) != 0), AW'($urandom_range(7)), rnd_data());
      end
      rsv_valid = ($urandom_range(1) == 1);
      rsv_addr  = AW'($urandom_range(7));
      qry_addr  = {AW'($urandom_range(7)), AW'($urandom_range(7))};
      flush     = ($urandom_range(15) == 0);
      nxt();
    end
    req_valid = '0;
    rsv_valid = 1'b0;
    flush     = 1'b0;
    nxt(); nxt();
    smp();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
